// File: rtl/maxnet_ctrl.sv
// Start/done sequencing controller for the four-unit cellular MaxNet datapath.
// Optional iteration limit enabled by defining MAXNET_CTRL_TIMEOUT_EN.
module maxnet_ctrl #(
    parameter int WIDTH    = 5,
    parameter int MAX_ITER = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pu_out1,
    input  logic [WIDTH-1:0] pu_out2,
    input  logic [WIDTH-1:0] pu_out3,
    input  logic [WIDTH-1:0] pu_out4,
    output logic             ld_x,
    output logic             en_pu,
    output logic             busy,
    output logic             done,
    output logic [1:0]       winner,
    output logic             win_valid,
    output logic             timeout,
    output logic [4:0]       iter_cnt
);

`ifdef MAXNET_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_STEP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic       ld_x_q, ld_x_d;
    logic       en_pu_q, en_pu_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [1:0] winner_q, winner_d;
    logic       win_valid_q, win_valid_d;
    logic       timeout_q, timeout_d;
    logic [4:0] iter_cnt_q, iter_cnt_d;

    logic [WIDTH-1:0] pu [4];
    logic [3:0]       alive;
    logic [2:0]       alive_cnt;
    logic [1:0]       alive_idx;
    logic             limit_hit;

    function automatic logic is_alive(input logic [WIDTH-1:0] v);
        return !v[WIDTH-1] && (v != '0);
    endfunction

    always_comb begin
        pu[0] = pu_out1;
        pu[1] = pu_out2;
        pu[2] = pu_out3;
        pu[3] = pu_out4;
        alive     = '0;
        alive_cnt = '0;
        alive_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            alive[i]  = is_alive(pu[i]);
            alive_cnt = alive_cnt + 3'(alive[i]);
            if (alive[i]) alive_idx = 2'(i);
        end
        // Constant-folds away when the limit is disabled.
        limit_hit = TIMEOUT_EN && (iter_cnt_q == 5'(MAX_ITER));
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        win_valid_d = win_valid_q;
        timeout_d   = timeout_q;
        iter_cnt_d  = iter_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    winner_d    = '0;
                    win_valid_d = 1'b0;
                    timeout_d   = 1'b0;
                    iter_cnt_d  = '0;
                end
            end
            S_LOAD:  state_d = S_CHECK;
            S_CHECK: begin
                if (alive_cnt == 3'd1) begin
                    winner_d    = alive_idx;
                    win_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (alive_cnt == 3'd0) begin
                    winner_d    = '0;
                    win_valid_d = 1'b0;
                    state_d     = S_DONE;
                end else if (limit_hit) begin
                    timeout_d   = 1'b1;
                    win_valid_d = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_STEP;
                    if (iter_cnt_q != '1) iter_cnt_d = iter_cnt_q + 5'd1;
                end
            end
            S_STEP:  state_d = S_CHECK;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Strobes are decoded from the next state so they line up with the registered state.
        ld_x_d  = (state_d == S_LOAD);
        en_pu_d = (state_d == S_STEP);
        busy_d  = (state_d == S_LOAD) || (state_d == S_CHECK) || (state_d == S_STEP);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ld_x_q      <= 1'b0;
            en_pu_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            winner_q    <= '0;
            win_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            iter_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ld_x_q      <= ld_x_d;
            en_pu_q     <= en_pu_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            winner_q    <= winner_d;
            win_valid_q <= win_valid_d;
            timeout_q   <= timeout_d;
            iter_cnt_q  <= iter_cnt_d;
        end
    end

    assign ld_x      = ld_x_q;
    assign en_pu     = en_pu_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign winner    = winner_q;
    assign win_valid = win_valid_q;
    assign timeout   = timeout_q;
    assign iter_cnt  = iter_cnt_q;

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Self-checking bench for maxnet_ctrl with a behavioural MaxNet PU datapath
// and an outcome-level reference model (MAXNET_CTRL_TIMEOUT_EN adds the limit case).
module tb_maxnet_ctrl;

`ifdef MAXNET_CTRL_TIMEOUT_EN
    localparam int MAXI  = 2;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MAXI  = 31;
    localparam bit TO_EN = 1'b0;
`endif

    typedef int vec_t [4];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] pu_out1, pu_out2, pu_out3, pu_out4;
    logic       ld_x, en_pu, busy, done, win_valid, timeout;
    logic [1:0] winner;
    logic [4:0] iter_cnt;

    int   n_assert = 0;
    int   n_fail   = 0;
    vec_t a   = '{0, 0, 0, 0};
    vec_t x   = '{0, 0, 0, 0};
    bit   freeze = 1'b0;

    always #5 clk = ~clk;

    maxnet_ctrl #(.WIDTH(5), .MAX_ITER(MAXI)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pu_out1(pu_out1), .pu_out2(pu_out2), .pu_out3(pu_out3), .pu_out4(pu_out4),
        .ld_x(ld_x), .en_pu(en_pu), .busy(busy), .done(done),
        .winner(winner), .win_valid(win_valid), .timeout(timeout), .iter_cnt(iter_cnt)
    );

    // a_i <- clamp(a_i + floor(-0.25 * sum_{j!=i} a_j)), 5-bit signed range kept non-overflowing
    function automatic vec_t pu_step(input vec_t v);
        vec_t r;
        int   s, n, q;
        for (int i = 0; i < 4; i++) begin
            s = 0;
            for (int j = 0; j < 4; j++) if (j != i) s += v[j];
            n = -s;
            q = (n >= 0) ? n / 4 : -((-n + 3) / 4);
            r[i] = v[i] + q;
            if (r[i] < 0)  r[i] = 0;
            if (r[i] > 15) r[i] = 15;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (ld_x)                 a <= x;
        else if (en_pu && !freeze) a <= pu_step(a);
    end

    assign pu_out1 = a[0][4:0];
    assign pu_out2 = a[1][4:0];
    assign pu_out3 = a[2][4:0];
    assign pu_out4 = a[3][4:0];

    task automatic ref_run(input vec_t x0, input bit frz, output int k, output int win,
                           output bit valid, output bit to);
        vec_t v = x0;
        int   cnt, idx;
        k = 0; win = 0; valid = 0; to = 0;
        for (int guard = 0; guard < 64; guard++) begin
            cnt = 0; idx = 0;
            for (int i = 0; i < 4; i++) if (v[i] > 0) begin cnt++; idx = i; end
            if (cnt == 1) begin win = idx; valid = 1; return; end
            if (cnt == 0) return;
            if (TO_EN && k == MAXI) begin to = 1; return; end
            if (!frz) v = pu_step(v);
            k++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_case(input string name, input vec_t xv, input bit frz);
        int k, win; bit valid, to;
        ref_run(xv, frz, k, win, valid, to);
        x = xv; freeze = frz;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 3 + 2 * k + 3; c++) begin
            @(negedge clk);
            chk($sformatf("%s ld_x c%0d", name, c), 32'(ld_x), 32'(c == 1));
            chk($sformatf("%s en_pu c%0d", name, c), 32'(en_pu),
                32'(c >= 3 && c <= 1 + 2 * k && (c % 2) == 1));
            chk($sformatf("%s done c%0d", name, c), 32'(done), 32'(c == 3 + 2 * k));
            chk($sformatf("%s busy c%0d", name, c), 32'(busy), 32'(c >= 1 && c <= 2 + 2 * k));
            if (c == 3 + 2 * k || c == 3 + 2 * k + 3) begin
                chk($sformatf("%s winner c%0d", name, c), 32'(winner), 32'(win));
                chk($sformatf("%s win_valid c%0d", name, c), 32'(win_valid), 32'(valid));
                chk($sformatf("%s timeout c%0d", name, c), 32'(timeout), 32'(to));
                chk($sformatf("%s iter_cnt c%0d", name, c), 32'(iter_cnt), 32'(k));
            end
        end
        freeze = 1'b0;
    endtask

    initial begin
        vec_t rv;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ld_x", 32'(ld_x), 0);
        chk("reset en_pu", 32'(en_pu), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset winner", 32'(winner), 0);
        chk("reset win_valid", 32'(win_valid), 0);
        chk("reset timeout", 32'(timeout), 0);
        chk("reset iter_cnt", 32'(iter_cnt), 0);
        rst = 1'b0;

        run_case("descending", '{8, 6, 4, 2}, 1'b0);
        run_case("single", '{0, 0, 6, 0}, 1'b0);
        run_case("tie", '{4, 4, 0, 0}, 1'b0);
        run_case("negatives", '{-3, 5, -1, 0}, 1'b0);
`ifdef MAXNET_CTRL_TIMEOUT_EN
        run_case("frozen_limit", '{3, 3, 0, 0}, 1'b1);
`endif

        // start held through DONE is accepted only on the following IDLE cycle
        x = '{0, 0, 6, 0};
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("hold ld_x c%0d", c), 32'(ld_x), 32'(c == 1 || c == 5));
            chk($sformatf("hold done c%0d", c), 32'(done), 32'(c == 3 || c == 7));
            if (c == 5) start = 1'b0;
        end

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 4; i++) rv[i] = int'($urandom_range(19)) - 4;
            run_case($sformatf("rand%0d", r), rv, 1'b0);
        end

        // extra starts mid-run are ignored; rst at iteration 1 aborts silently
        x = '{8, 6, 4, 2};
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) start = 1'b1;
            if (c == 3) begin
                chk("abort ld_x step", 32'(ld_x), 0);
                chk("abort en_pu step", 32'(en_pu), 1);
            end
            if (c == 4) begin
                chk("abort ld_x check", 32'(ld_x), 0);
                chk("abort iter_cnt", 32'(iter_cnt), 1);
                start = 1'b0;
                rst = 1'b1;
            end
            if (c == 5) begin
                chk("abort busy", 32'(busy), 0);
                chk("abort ld_x", 32'(ld_x), 0);
                chk("abort en_pu", 32'(en_pu), 0);
                chk("abort winner", 32'(winner), 0);
                chk("abort win_valid", 32'(win_valid), 0);
                chk("abort timeout", 32'(timeout), 0);
                chk("abort iter_cnt rst", 32'(iter_cnt), 0);
                rst = 1'b0;
            end
            if (c >= 5) begin
                chk($sformatf("abort done c%0d", c), 32'(done), 0);
                chk($sformatf("abort idle busy c%0d", c), 32'(busy), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/maxnet_ctrl.md
# maxnet_ctrl

Sequencing controller for the four-unit cellular MaxNet datapath (`maxnet_cellular` processing units, 5-bit signed fixed point, `01000` = 1.0). It accepts a start request, loads the inputs into the PUs, and steps one competition iteration at a time. After each step it checks the PU outputs for convergence. It then reports the winner index, iteration count and completion, replacing the free-running datapath with a start/done handshake.

## Interface
- `WIDTH`, 5, PU output width (signed, two's complement).
- `MAX_ITER`, 31, iteration limit; only used when `MAXNET_CTRL_TIMEOUT_EN` is defined; range 1..31.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request a new run; sampled only in IDLE.
- `pu_out1`..`pu_out4`  in  WIDTH  registered PU activations from the datapath.
- `ld_x`  out  1  load x1..x4 into the PUs (one cycle).
- `en_pu`  out  1  perform one MaxNet iteration in all PUs (one cycle).
- `busy`  out  1  high from LOAD through CHECK/STEP; low in IDLE and DONE.
- `done`  out  1  one-cycle completion pulse.
- `winner`  out  2  index of the surviving PU (0 = pu_out1 … 3 = pu_out4).
- `win_valid`  out  1  exactly one PU survived.
- `timeout`  out  1  run ended on the iteration limit.
- `iter_cnt`  out  5  number of `en_pu` pulses issued in the current or last run.

## Operation
- States: IDLE, LOAD, CHECK, STEP, DONE.
- IDLE: `start`=1 → LOAD. Clear `iter_cnt`, `winner`, `win_valid` and `timeout` on this transition.
- LOAD: `ld_x`=1 → CHECK.
- CHECK: evaluate the PU outputs combinationally:
  - A PU is alive when its value is > 0, i.e. MSB=0 and value ≠ 0. Negative values count as dead.
  - `alive_cnt` is the number of alive PUs (0..4).
  - `alive_cnt`==1: latch `winner` = that index and set `win_valid`=1. Go to DONE.
  - `alive_cnt`==0: set `win_valid`=0 and `winner`=0. Go to DONE.
  - `alive_cnt`≥2 and the limit is reached (`iter_cnt`==`MAX_ITER`, macro on): set `timeout`=1 and `win_valid`=0. Go to DONE.
  - Otherwise go to STEP.
- STEP: `en_pu`=1, `iter_cnt`+=1 (saturating at 31) → CHECK.
- DONE: `done`=1 for this cycle only → IDLE.
- Result outputs (`winner`, `win_valid`, `timeout`, `iter_cnt`) hold their values until the next accepted `start`.
- `start` outside IDLE is ignored. `start` held high in DONE does not retrigger until the FSM is back in IDLE; it is accepted on the IDLE cycle.
- `ld_x` and `en_pu` are never high together and are never high outside LOAD/STEP.

## Timing
- Reset: state=IDLE. All outputs are 0: `ld_x`, `en_pu`, `busy`, `done`, `winner`, `win_valid`, `timeout` and `iter_cnt`.
- `rst` mid-run forces IDLE on the next edge and aborts without a `done` pulse.
- Outputs are registered or decoded from the state register; there is no combinational path from `pu_out*` to any output.
- `start` sampled at edge t gives LOAD in cycle t+1 and the first CHECK at t+2.
- Each iteration takes 2 cycles (STEP, CHECK).
- The datapath must present updated `pu_out*` in the cycle after `ld_x`/`en_pu`.
- Latency from `start` to `done` = 3 + 2·k cycles, where k = final `iter_cnt`.

## Configuration
- `MAXNET_CTRL_TIMEOUT_EN` defined: enforces the `MAX_ITER` limit and drives `timeout`.
- Not defined: no limit. The FSM iterates until `alive_cnt` ≤ 1, `timeout` is tied 0 and the `MAX_ITER` comparator is removed.

## Test plan
The bench uses a behavioural PU model: a_i ← max(0, a_i + floor(ε·Σ_{j≠i} a_j)), with ε = `11110` (−0.25).

- Reset, then x = (`01000`,`00110`,`00100`,`00010`) and a `start` pulse. Required: `ld_x` at t+1; `en_pu` at t+3 and t+5. Activations go (8,6,4,2) → (5,2,0,0) → (4,0,0,0). `done` at t+7 with `winner`=0, `win_valid`=1, `iter_cnt`=2, `timeout`=0.
- x = (`00000`,`00000`,`00110`,`00000`). Required: `done` at t+3, `iter_cnt`=0, `winner`=2, `win_valid`=1, no `en_pu` pulse.
- x = (`00100`,`00100`,`00000`,`00000`), equal competitors. Required: both PUs reach 0 in the same step, `win_valid`=0, `winner`=0, `done` pulse, no hang.
- Macro on, `MAX_ITER`=2, bench PU model frozen so outputs stay (3,3,0,0). Required: `done` at t+7, `timeout`=1, `win_valid`=0, `iter_cnt`=2.
- `start` pulses during STEP/CHECK, then `rst` asserted mid-run at iteration 1. Required: extra starts are ignored, the FSM returns to IDLE the cycle after `rst`, all outputs read 0, and there is no `done` pulse.
